pc_seq_ctrl: RTL

- Next-PC sequencer for the MIPS150 pipeline.
- Drives the PC register's select code, enable and flush lines from branch, jump and hazard events.
- Counts out post-redirect bubble cycles and freezes fetch on load-use and memory stalls.
- Sits between the decode/execute control logic and the PC register.

---
 rtl/pc_seq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer for the MIPS150 pipeline.
// Turns branch, jump and hazard events into the PC select code, the PC
// write enable, a redirect flush pulse, and IF-kill / ID-stall strobes.
// After a redirect it counts out fetch bubbles. It freezes fetch on
// load-use hazards and on memory stalls.
// Optional build macro PC_SEQ_PERF_EN adds the stall_cnt and redirect_cnt
// performance counters.
module pc_seq_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,  // fetch bubbles after a redirect (1..7)
  parameter int unsigned BOOT_CYCLES  = 1   // PC_EN low cycles after reset (1..7)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       branch_taken,
  input  logic       jr_ID,
  input  logic       jal_ID,
  input  logic       load_use,
  input  logic       mem_stall,
  output logic [1:0] PC_Sel,
  output logic       PC_EN,
  output logic       flush,
  output logic       kill_IF,
  output logic       stall_ID
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b11;
  localparam logic [1:0] SEL_JR  = 2'b00;

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] BOOT_LD  = 3'(BOOT_CYCLES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bub_q, bub_d;
  logic [2:0] boot_q, boot_d;

  logic       do_redir;
  logic [1:0] redir_sel;

  // Redirect target select: branch over JR over J/JAL.
  always_comb begin
    if (branch_taken)  redir_sel = SEL_BR;
    else if (jr_ID)    redir_sel = SEL_JR;
    else if (jal_ID)   redir_sel = SEL_J;
    else               redir_sel = SEL_PC4;
  end

  // Next-state and output decode. mem_stall takes precedence in every
  // non-boot state. The redirect action is shared by RUN, STALL and FLUSH.
  always_comb begin
    state_d  = state_q;
    bub_d    = bub_q;
    boot_d   = boot_q;
    PC_Sel   = SEL_PC4;
    PC_EN    = 1'b0;
    flush    = 1'b0;
    kill_IF  = 1'b0;
    stall_ID = 1'b0;
    do_redir = 1'b0;

    unique case (state_q)
      BOOT: begin
        if (boot_q != 3'd0) boot_d = boot_q - 3'd1;
        if (boot_q <= 3'd1) state_d = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          PC_EN = 1'b0;
        end else if (branch_taken || jr_ID || jal_ID) begin
          do_redir = 1'b1;
        end else if (load_use) begin
          stall_ID = 1'b1;
          state_d  = STALL;
        end else begin
          PC_EN = 1'b1;
        end
      end
      STALL: begin
        if (mem_stall) begin
          stall_ID = 1'b1;
        end else if (branch_taken) begin
          do_redir = 1'b1;
        end else begin
          stall_ID = 1'b1;
          state_d  = RUN;
        end
      end
      FLUSH: begin
        // jr_ID, jal_ID and load_use come from killed instructions here.
        kill_IF = 1'b1;
        if (mem_stall) begin
          PC_EN = 1'b0;
        end else if (branch_taken) begin
          do_redir = 1'b1;
        end else begin
          PC_EN = 1'b1;
          if (bub_q != 3'd0) bub_d = bub_q - 3'd1;
          if (bub_q <= 3'd1) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (do_redir) begin
      PC_Sel  = redir_sel;
      PC_EN   = 1'b1;
      flush   = 1'b1;
      kill_IF = 1'b1;
      bub_d   = FLUSH_LD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= BOOT;
      bub_q   <= '0;
      boot_q  <= BOOT_LD;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      boot_q  <= boot_d;
    end
  end

`ifdef PC_SEQ_PERF_EN
  // Performance counters: frozen-fetch cycles outside boot, and flush pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (state_q != BOOT && !PC_EN) stall_cnt <= stall_cnt + 32'd1;
      if (flush) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
